// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART calculator datapath: FSM encoding, ASCII constants
// and the decimal power-of-ten table used by both the receive parser and the result sender.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SIGN,
    ST_DIGIT,
    ST_SEND,
    ST_WAIT,
    ST_TERM,
    ST_FIN
  } state_e;

  // Identifies which kind of byte is in flight so WAIT knows where to go next.
  typedef enum logic [1:0] {
    BYTE_DIGIT,
    BYTE_SIGN,
    BYTE_TERM
  } byte_kind_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  localparam logic [3:0] LAST_IDX  = 4'd9;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  localparam logic [31:0] POW10 [0:9] = '{
    32'd1,
    32'd10,
    32'd100,
    32'd1000,
    32'd10000,
    32'd100000,
    32'd1000000,
    32'd10000000,
    32'd100000000,
    32'd1000000000
  };

endpackage

// File: rtl/pow10_table.sv
// Combinational decimal weight lookup: idx 0..9 -> 10**idx, anything larger -> 0.
module pow10_table
  import uart_alu_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [31:0] pow
);

  always_comb begin
    pow = '0;
    case (idx)
      4'd0:    pow = POW10[0];
      4'd1:    pow = POW10[1];
      4'd2:    pow = POW10[2];
      4'd3:    pow = POW10[3];
      4'd4:    pow = POW10[4];
      4'd5:    pow = POW10[5];
      4'd6:    pow = POW10[6];
      4'd7:    pow = POW10[7];
      4'd8:    pow = POW10[8];
      4'd9:    pow = POW10[9];
      default: pow = '0;
    endcase
  end

endmodule

// File: rtl/result_ascii_tx.sv
// Converts a 32-bit ALU result to decimal ASCII (MSD first, no leading zeros) and streams it
// byte-by-byte to the UART TX, optionally followed by a terminator. Build option: SIGNED_OUT_EN.
module result_ascii_tx
  import uart_alu_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = ASCII_SPACE,
  parameter bit         SEND_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic        tx_done,
  output logic [7:0]  d_out,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  state_e     state_q, state_d;
  byte_kind_e kind_q, kind_d;
  logic [31:0] rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        started_q, started_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] pow_cur;
  logic [32:0] diff;
  logic        rem_ge_pow;

  pow10_table u_pow10 (
    .idx (idx_q),
    .pow (pow_cur)
  );

  // Borrow-out of the 33-bit subtraction doubles as the compare result.
  assign diff       = {1'b0, rem_q} - {1'b0, pow_cur};
  assign rem_ge_pow = ~diff[32];

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    started_d  = started_q;
    d_out_d    = d_out_q;
    busy_d     = busy_q;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = result;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        idx_d     = LAST_IDX;
        cnt_d     = '0;
        started_d = 1'b0;
        state_d   = ST_DIGIT;
`ifdef SIGNED_OUT_EN
        if (rem_q[31]) state_d = ST_SIGN;
`endif
      end

`ifdef SIGNED_OUT_EN
      ST_SIGN: begin
        rem_d      = -rem_q;
        d_out_d    = ASCII_MINUS;
        kind_d     = BYTE_SIGN;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
`endif

      ST_DIGIT: begin
        if (rem_ge_pow && (cnt_q != MAX_DIGIT)) begin
          rem_d = diff[31:0];
          cnt_d = cnt_q + 4'd1;
        end else if ((cnt_q != 4'd0) || started_q || (idx_q == 4'd0)) begin
          d_out_d    = ASCII_0 + {4'd0, cnt_q};
          started_d  = 1'b1;
          kind_d     = BYTE_DIGIT;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end else begin
          idx_d = idx_q - 4'd1;
          cnt_d = '0;
        end
      end

      ST_SEND: state_d = ST_WAIT;

      ST_WAIT: begin
        if (tx_done) begin
          case (kind_q)
            BYTE_SIGN: state_d = ST_DIGIT;
            BYTE_TERM: begin
              done_d  = 1'b1;
              state_d = ST_FIN;
            end
            default: begin
              if (idx_q != 4'd0) begin
                idx_d   = idx_q - 4'd1;
                cnt_d   = '0;
                state_d = ST_DIGIT;
              end else if (SEND_TERM) begin
                state_d = ST_TERM;
              end else begin
                done_d  = 1'b1;
                state_d = ST_FIN;
              end
            end
          endcase
        end
      end

      ST_TERM: begin
        d_out_d    = TERM_CHAR;
        kind_d     = BYTE_TERM;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      kind_q     <= BYTE_DIGIT;
      rem_q      <= '0;
      idx_q      <= LAST_IDX;
      cnt_q      <= '0;
      started_q  <= 1'b0;
      d_out_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      started_q  <= started_d;
      d_out_q    <= d_out_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign d_out    = d_out_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
